atom_nr1w: RTL and testbench

//  Parametrised behavioural memory model: NUMRDPT read ports, one write port, fixed read latency.

---
 rtl/atom_nr1w_if.sv | 17 +
 rtl/atom_nr1w.sv | 84 ++++++++
 tb/tb_atom_nr1w.sv | 122 ++++++++++++
 3 files changed

// File: rtl/atom_nr1w_if.sv
// atom_nr1w_if: read/write port bundle for the atom_nr1w memory model.
interface atom_nr1w_if #(
   parameter int NUMRDPT = 2,
   parameter int BITADDR = 3,
   parameter int BITDATA = 1
);
   logic                       ready;
   logic [NUMRDPT-1:0]         read;
   logic [NUMRDPT*BITADDR-1:0] rd_adr;
   logic [NUMRDPT*BITDATA-1:0] rd_dout;
   logic [NUMRDPT-1:0]         rd_vld;
   logic                       write;
   logic [BITADDR-1:0]         wr_adr;
   logic [BITDATA-1:0]         wr_din;
   modport master (input ready, rd_dout, rd_vld, output read, rd_adr, write, wr_adr, wr_din);
   modport slave (output ready, rd_dout, rd_vld, input read, rd_adr, write, wr_adr, wr_din);
endinterface

// File: rtl/atom_nr1w.sv
// atom_nr1w: N-read/1-write memory model with fixed read latency and reset-init sweep.
// Define ATOM_NR1W_WRBYPASS_EN for write-first reads (same-cycle write data forwarded to readers).
module atom_nr1w #(
   parameter int NUMADDR    = 8,
   parameter int BITADDR    = 3,
   parameter int BITDATA    = 1,
   parameter int NUMRDPT    = 2,
   parameter int SRAM_DELAY = 1,
   parameter int RSTINIT    = 0,
   parameter int RSTSTRT    = 0,
   parameter int RSTINCR    = 0
) (
   input logic        clk,
   input logic        rst_n,
   atom_nr1w_if.slave bus
);
   localparam logic [BITADDR:0]   LIM  = (BITADDR+1)'(NUMADDR);
   localparam logic [BITADDR-1:0] LAST = BITADDR'(NUMADDR-1);
   typedef enum logic {INIT, READY} state_t;
   state_t                     r_state, w_nxt;
   logic [BITADDR-1:0]         r_cnt;
   logic                       r_ready;
   logic [BITDATA-1:0]         r_mem [NUMADDR];
   logic                       w_wen;
   logic [BITDATA-1:0]         w_init;
   logic [NUMRDPT-1:0]         w_vld;
   logic [NUMRDPT*BITDATA-1:0] w_dout;
   always_comb begin
      w_nxt = (r_state == INIT && r_cnt == LAST) ? READY : r_state;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= (RSTINIT != 0) ? INIT : READY;
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_cnt   <= (r_state == INIT) ? r_cnt + 1'b1 : '0;
         r_ready <= w_nxt == READY;
      end
   assign w_init = BITDATA'(RSTSTRT + int'(r_cnt) * RSTINCR);
   assign w_wen  = r_ready & bus.write & ({1'b0, bus.wr_adr} < LIM);
   always_ff @(posedge clk)
      if (r_state == INIT) r_mem[r_cnt] <= w_init;
      else if (w_wen) r_mem[bus.wr_adr] <= bus.wr_din;
   for (genvar p = 0; p < NUMRDPT; p++) begin : g_port
      logic [BITADDR-1:0] w_adr;
      logic               w_req, w_inr;
      logic [BITDATA-1:0] w_dat;
      assign w_adr = bus.rd_adr[p*BITADDR +: BITADDR];
      assign w_req = r_ready & bus.read[p];
      assign w_inr = {1'b0, w_adr} < LIM;
`ifdef ATOM_NR1W_WRBYPASS_EN
      assign w_dat = !w_inr ? '0 : (w_wen && bus.wr_adr == w_adr) ? bus.wr_din : r_mem[w_adr];
`else
      assign w_dat = w_inr ? r_mem[w_adr] : '0;
`endif
      if (SRAM_DELAY == 0) begin : g_comb
         assign w_vld[p] = w_req;
         assign w_dout[p*BITDATA +: BITDATA] = w_req ? w_dat : '0;
      end else begin : g_pipe
         // data is zeroed at capture so an idle slot never carries stale contents
         logic [SRAM_DELAY-1:0] r_vld;
         logic [BITDATA-1:0]    r_dat [SRAM_DELAY];
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
               r_vld <= '0;
               r_dat <= '{default: '0};
            end else begin
               r_vld[0] <= w_req;
               r_dat[0] <= w_req ? w_dat : '0;
               for (int i = 1; i < SRAM_DELAY; i++) begin
                  r_vld[i] <= r_vld[i-1];
                  r_dat[i] <= r_dat[i-1];
               end
            end
         assign w_vld[p] = r_vld[SRAM_DELAY-1];
         assign w_dout[p*BITDATA +: BITDATA] = r_dat[SRAM_DELAY-1];
      end
   end
   assign bus.ready   = r_ready;
   assign bus.rd_vld  = w_vld;
   assign bus.rd_dout = w_dout;
endmodule

// File: tb/tb_atom_nr1w.sv
// tb_atom_nr1w: randomized scoreboard bench for atom_nr1w (both bypass builds).
module tb_atom_nr1w;
   localparam int N = 8, BA = 4, BD = 8, P = 2, D = 2;
   typedef struct {int due; int port; logic [BD-1:0] d;} exp_t;
   logic clk = 1'b0, rst_n = 1'b0;
   int cyc = 0, n_chk = 0, n_fail = 0;
   logic [BD-1:0] mdl [N];
   exp_t q[$];
   atom_nr1w_if #(.NUMRDPT(P), .BITADDR(BA), .BITDATA(BD)) bus ();
   atom_nr1w #(.NUMADDR(N), .BITADDR(BA), .BITDATA(BD), .NUMRDPT(P), .SRAM_DELAY(D),
      .RSTINIT(1), .RSTSTRT(3), .RSTINCR(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
      end
   endtask
   function automatic logic [BD-1:0] ref_rd(input logic [BA-1:0] a, input logic w,
                                             input logic [BA-1:0] wa, input logic [BD-1:0] wd);
      if (int'(a) >= N) return '0;
`ifdef ATOM_NR1W_WRBYPASS_EN
      if (w && wa == a) return wd;
`endif
      return mdl[a];
   endfunction
   task automatic drive(input logic r0, input logic [BA-1:0] a0, input logic r1, input logic [BA-1:0] a1,
                        input logic w, input logic [BA-1:0] wa, input logic [BD-1:0] wd);
      bus.read = {r1, r0}; bus.rd_adr = {a1, a0};
      bus.write = w; bus.wr_adr = wa; bus.wr_din = wd;
      if (bus.ready === 1'b1) begin
         if (r0) q.push_back('{cyc + D, 0, ref_rd(a0, w, wa, wd)});
         if (r1) q.push_back('{cyc + D, 1, ref_rd(a1, w, wa, wd)});
         if (w && int'(wa) < N) mdl[wa] = wd;
      end
      @(posedge clk); #1;
   endtask
   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask
   // steps the sweep while poking reads/writes that must all be ignored
   task automatic wait_ready(output int n);
      n = 0;
      while (bus.ready !== 1'b1 && n < 20) begin
         drive(1, 3, 1, 12, n >= 2, 0, 8'h55);
         n++;
      end
   endtask
   always @(negedge clk) if (rst_n) begin
      for (int p = 0; p < P; p++) begin
         logic [BD-1:0] d;
         int idx;
         d = bus.rd_dout[p*BD +: BD];
         idx = -1;
         for (int i = 0; i < q.size(); i++) if (idx < 0 && q[i].port == p) idx = i;
         n_chk++;
         if (bus.rd_vld[p] === 1'b1) begin
            if (idx < 0) begin
               n_fail++;
               $display("FAIL unexpected_vld port%0d cycle %0d data %0h expected no valid", p, cyc, d);
            end else begin
               if (q[idx].due != cyc || q[idx].d !== d) begin
                  n_fail++;
                  $display("FAIL rd_data port%0d: got %0h at cycle %0d expected %0h at cycle %0d",
                           p, d, cyc, q[idx].d, q[idx].due);
               end
               q.delete(idx);
            end
         end else if (d !== '0) begin
            n_fail++;
            $display("FAIL stale_dout port%0d: got %0h expected 0 (cycle %0d)", p, d, cyc);
         end
      end
      while (q.size() > 0 && q[0].due <= cyc) begin
         n_chk++; n_fail++;
         $display("FAIL missing_vld port%0d: got none expected %0h at cycle %0d", q[0].port, q[0].d, q[0].due);
         void'(q.pop_front());
      end
   end
   initial begin
      int n;
      bus.read = '0; bus.rd_adr = '0; bus.write = 0; bus.wr_adr = '0; bus.wr_din = '0;
      for (int i = 0; i < N; i++) mdl[i] = BD'(3 + 2 * i);
      #12;
      check("reset_ready", bus.ready, 0);
      check("reset_vld", bus.rd_vld, 0);
      check("reset_dout", bus.rd_dout, 0);
      @(posedge clk); #1;
      rst_n = 1;
      for (int i = 0; i < 4; i++) drive(1, 2, 1, 5, 1, 0, 8'h55);
      rst_n = 0; #1;
      check("midinit_ready", bus.ready, 0);
      check("midinit_vld", bus.rd_vld, 0);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1;
      wait_ready(n);
      check("init_cycles", n, N);
      for (int i = 0; i < N; i++) drive(1, BA'(i), 1, BA'(N - 1 - i), 0, 0, 0);
      drive(0, 0, 0, 0, 1, 5, 8'h0A);
      drive(1, 5, 1, 5, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 2, 8'h07);
      drive(1, 2, 1, 2, 1, 2, 8'h01);
      drive(1, 2, 1, 12, 1, 12, 8'hEE);
      drive(1, 12, 1, 15, 0, 0, 0);
      for (int i = 0; i < 400; i++)
         drive($urandom_range(0, 1), BA'($urandom_range(0, 11)), $urandom_range(0, 1),
               BA'($urandom_range(0, 11)), $urandom_range(0, 1), BA'($urandom_range(0, 11)),
               BD'($urandom));
      for (int i = 0; i < N; i++) drive(1, BA'(i), 1, BA'(i), 0, 0, 0);
      repeat (D + 3) idle();
      check("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
